// File: rtl/conv_encoder_tailed_pkg.sv
// Shared types, default code and parity helper for the tailed convolutional encoder.
package conv_enc_pkg;

  typedef enum logic {
    DATA = 1'b0,
    TAIL = 1'b1
  } state_e;

  localparam int KMAX = 9;

  // Classic K=3 rate-1/2 code: generator 0 = 111, generator 1 = 101.
  localparam logic [5:0] G_K3_R2 = {3'b101, 3'b111};

  function automatic logic parity(input logic [KMAX-1:0] taps, input logic [KMAX-1:0] gen);
    return ^(taps & gen);
  endfunction

endpackage

// File: rtl/conv_encoder_tailed_if.sv
// Input bit stream and output symbol stream of the encoder, both valid/ready.
interface conv_encoder_tailed_if #(
  parameter int N = 2
);
  logic         in_valid;
  logic         in_ready;
  logic         in_bit;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_sym;
  logic         out_last;

  modport master (
    output in_valid, in_bit, in_last, out_ready,
    input  in_ready, out_valid, out_sym, out_last
  );

  modport slave (
    input  in_valid, in_bit, in_last, out_ready,
    output in_ready, out_valid, out_sym, out_last
  );
endinterface

// File: rtl/conv_encoder_tailed.sv
// Rate-1/N constraint-length-K convolutional encoder with back-pressure and
// optional zero-tail flushing so every frame ends with the trellis in state 0.
module conv_encoder_tailed
  import conv_enc_pkg::*;
#(
  parameter int             K         = 3,
  parameter int             N         = 2,
  parameter logic [N*K-1:0] G         = G_K3_R2,
  parameter bit             TERMINATE = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  conv_encoder_tailed_if.slave bus,
  output logic                 busy
);

  localparam int CW = $clog2(K) + 1;

  if (K < 2 || K > KMAX || N < 2 || N > 4 || $bits(G) != N * K) begin : g_param_check
    $error("conv_encoder_tailed: illegal K, N or G width");
  end

  function automatic logic [N-1:0] encode(input logic b, input logic [K-2:0] s);
    logic [KMAX-1:0] taps;
    logic [N-1:0]    sym;
    sym  = '0;
    taps = KMAX'({s, b});
    for (int i = 0; i < N; i++) begin
      sym[i] = parity(taps, KMAX'(G[i*K +: K]));
    end
    return sym;
  endfunction

  // Written via a K-bit temporary so K=2 needs no empty part-select.
  function automatic logic [K-2:0] shift_in(input logic b, input logic [K-2:0] s);
    logic [K-1:0] t;
    t = {s, b};
    return t[K-2:0];
  endfunction

  state_e        state_q, state_d;
  logic [K-2:0]  sr_q, sr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ov_q, ov_d;
  logic [N-1:0]  sym_q, sym_d;
  logic          last_q, last_d;
  logic          slot_free;

  assign slot_free = !ov_q || bus.out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= DATA;
      sr_q    <= '0;
      cnt_q   <= '0;
      ov_q    <= 1'b0;
      sym_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      ov_q    <= ov_d;
      sym_q   <= sym_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    ov_d    = ov_q;
    sym_d   = sym_q;
    last_d  = last_q;
    if (slot_free) begin
      ov_d = 1'b0;
      unique case (state_q)
        DATA: begin
          if (bus.in_valid) begin
            ov_d   = 1'b1;
            sym_d  = encode(bus.in_bit, sr_q);
            last_d = 1'b0;
            sr_d   = shift_in(bus.in_bit, sr_q);
            if (bus.in_last) begin
              if (TERMINATE) begin
                cnt_d   = CW'(K - 1);
                state_d = TAIL;
              end else begin
                // Truncated frame: restart the next frame from state 0.
                last_d = 1'b1;
                sr_d   = '0;
              end
            end
          end
        end
        TAIL: begin
          ov_d  = 1'b1;
          sym_d = encode(1'b0, sr_q);
          sr_d  = shift_in(1'b0, sr_q);
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            last_d  = 1'b1;
            state_d = DATA;
          end else begin
            last_d = 1'b0;
          end
        end
        default: state_d = DATA;
      endcase
    end
  end

  always_comb begin
    bus.in_ready = (state_q == DATA) && slot_free;
    busy         = (state_q == TAIL) || ov_q;
  end

  assign bus.out_valid = ov_q;
  assign bus.out_sym   = sym_q;
  assign bus.out_last  = last_q;

endmodule

// File: tb/tb_conv_encoder_tailed.sv
// Bench for conv_encoder_tailed: default, non-terminating and K=5/N=3 instances.
module tb_conv_encoder_tailed;

  localparam logic [14:0] G_C = {5'b11011, 5'b10101, 5'b10011};
  localparam int KC = 5;
  localparam int NC = 3;
  localparam int BUDGET = 5000;

  typedef struct packed {
    logic       vin;
    logic       b;
    logic       l;
    logic       rdy;
    logic       e_ov;
    logic       e_irdy;
    logic       e_last;
    logic [1:0] e_sym;
  } vec_t;

  logic       clk;
  logic       reset;
  logic       vin   [3];
  logic       bitv  [3];
  logic       lastv [3];
  logic       ordy  [3];
  logic       ov    [3];
  logic       irdy  [3];
  logic       olast [3];
  logic [2:0] sym_v [3];
  logic       busy_v[3];

  int checks = 0;
  int errors = 0;

  logic       s_bit [$];
  logic       s_last[$];
  int         lens  [$];
  logic [3:0] got_q [$];
  logic [3:0] exp_q [$];
  vec_t       tbl   [17];

  conv_encoder_tailed_if #(.N(2))  ia ();
  conv_encoder_tailed_if #(.N(2))  ib ();
  conv_encoder_tailed_if #(.N(NC)) ic ();

  conv_encoder_tailed dut_a (.clk(clk), .reset(reset), .bus(ia), .busy(busy_v[0]));
  conv_encoder_tailed #(.TERMINATE(1'b0)) dut_b (.clk(clk), .reset(reset), .bus(ib), .busy(busy_v[1]));
  conv_encoder_tailed #(.K(KC), .N(NC), .G(G_C)) dut_c (.clk(clk), .reset(reset), .bus(ic), .busy(busy_v[2]));

  assign ia.in_valid = vin[0];  assign ia.in_bit = bitv[0];  assign ia.in_last = lastv[0];  assign ia.out_ready = ordy[0];
  assign ib.in_valid = vin[1];  assign ib.in_bit = bitv[1];  assign ib.in_last = lastv[1];  assign ib.out_ready = ordy[1];
  assign ic.in_valid = vin[2];  assign ic.in_bit = bitv[2];  assign ic.in_last = lastv[2];  assign ic.out_ready = ordy[2];
  assign ov[0] = ia.out_valid;  assign irdy[0] = ia.in_ready;  assign olast[0] = ia.out_last;  assign sym_v[0] = {1'b0, ia.out_sym};
  assign ov[1] = ib.out_valid;  assign irdy[1] = ib.in_ready;  assign olast[1] = ib.out_last;  assign sym_v[1] = {1'b0, ib.out_sym};
  assign ov[2] = ic.out_valid;  assign irdy[2] = ic.in_ready;  assign olast[2] = ic.out_last;  assign sym_v[2] = ic.out_sym;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  function automatic vec_t v(input logic [3:0] in, input logic [2:0] e, input logic [1:0] s);
    return vec_t'({in, e, s});
  endfunction

  // Convolution straight from the code definition: symbol n, generator i is the
  // XOR of frame bits x[n-j] over the taps j, with x = 0 outside the frame.
  function automatic void model_frame(input int base, input int len, input int k, input int n,
                                      input logic [35:0] g, input bit term);
    int total;
    total = term ? len + k - 1 : len;
    for (int s = 0; s < total; s++) begin
      logic [2:0] sy;
      sy = '0;
      for (int i = 0; i < n; i++)
        for (int j = 0; j < k; j++)
          if (g[i*k + j] && (s - j) >= 0 && (s - j) < len) sy[i] = sy[i] ^ s_bit[base + s - j];
      exp_q.push_back({(s == total - 1), sy});
    end
  endfunction

  task automatic push_exp(input logic last, input logic [1:0] s);
    exp_q.push_back({last, 1'b0, s});
  endtask

  task automatic cmp_q(input string name);
    chk({name, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_sym%0d", name, i), got_q[i], exp_q[i]);
  endtask

  // Feeds s_bit/s_last into DUT sel, collects accepted symbols into got_q.
  // mode 0: out_ready=1, mode 1: out_ready 1,0,0,1 repeating, mode 2: random both sides.
  task automatic stream(input int sel, input int mode);
    int idx = 0;
    int cyc = 0;
    logic p_ov = 1'b0, p_rdy = 1'b1, p_last = 1'b0;
    logic [2:0] p_sym = '0;
    got_q.delete();
    while ((idx < s_bit.size() || busy_v[sel]) && cyc < BUDGET) begin
      case (mode)
        1:       ordy[sel] = (cyc % 4 == 0) || (cyc % 4 == 3);
        2:       ordy[sel] = ($urandom_range(0, 2) != 0);
        default: ordy[sel] = 1'b1;
      endcase
      if (idx < s_bit.size() && (mode != 2 || $urandom_range(0, 3) != 0)) begin
        vin[sel] = 1'b1; bitv[sel] = s_bit[idx]; lastv[sel] = s_last[idx];
      end else begin
        vin[sel] = 1'b0; bitv[sel] = 1'($urandom_range(0, 1)); lastv[sel] = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      if (p_ov && !p_rdy)
        chk($sformatf("stall_hold_dut%0d", sel), {ov[sel], olast[sel], sym_v[sel]}, {1'b1, p_last, p_sym});
      if (ov[sel] && !ordy[sel])
        chk($sformatf("stall_in_ready_dut%0d", sel), irdy[sel], 1'b0);
      if (ov[sel] && ordy[sel]) got_q.push_back({olast[sel], sym_v[sel]});
      if (vin[sel] && irdy[sel]) idx++;
      p_ov = ov[sel]; p_rdy = ordy[sel]; p_last = olast[sel]; p_sym = sym_v[sel];
      @(posedge clk); #1;
      cyc++;
    end
    if (cyc >= BUDGET) begin
      errors++;
      $display("FAIL stream_timeout_dut%0d got=%0d cycles expected<%0d", sel, cyc, BUDGET);
    end
    vin[sel] = 1'b0;
    ordy[sel] = 1'b1;
  endtask

  task automatic set_frames(input logic [15:0] bits, input logic [15:0] lasts, input int n);
    s_bit.delete();
    s_last.delete();
    for (int i = 0; i < n; i++) begin
      s_bit.push_back(bits[i]);
      s_last.push_back(lasts[i]);
    end
  endtask

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      vin[i] = 1'b0; bitv[i] = 1'b0; lastv[i] = 1'b0; ordy[i] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    chk("rst_out_valid", ov[0], 1'b0);
    chk("rst_out_sym", sym_v[0], 3'b000);
    chk("rst_out_last", olast[0], 1'b0);
    chk("rst_busy", busy_v[0], 1'b0);
    chk("rst_in_ready", irdy[0], 1'b1);
    chk("rst_c_out_valid", ov[2], 1'b0);
    @(posedge clk); #1;

    // {vin,bit,last,rdy}, {ov,in_ready,last}, sym as {out_sym[1],out_sym[0]}
    tbl[0]  = v(4'b1101, 3'b010, 2'b00);
    tbl[1]  = v(4'b1001, 3'b110, 2'b11);
    tbl[2]  = v(4'b1101, 3'b110, 2'b01);
    tbl[3]  = v(4'b1111, 3'b110, 2'b00);
    tbl[4]  = v(4'b0001, 3'b100, 2'b10);
    tbl[5]  = v(4'b0001, 3'b100, 2'b10);
    tbl[6]  = v(4'b0001, 3'b111, 2'b11);
    tbl[7]  = v(4'b0001, 3'b010, 2'b00);
    tbl[8]  = v(4'b1101, 3'b010, 2'b00);
    tbl[9]  = v(4'b1111, 3'b110, 2'b11);
    tbl[10] = v(4'b1011, 3'b100, 2'b10);
    tbl[11] = v(4'b1011, 3'b100, 2'b10);
    tbl[12] = v(4'b1011, 3'b111, 2'b11);
    tbl[13] = v(4'b0001, 3'b100, 2'b00);
    tbl[14] = v(4'b0001, 3'b100, 2'b00);
    tbl[15] = v(4'b0001, 3'b111, 2'b00);
    tbl[16] = v(4'b0001, 3'b010, 2'b00);
    for (int i = 0; i < 17; i++) begin
      vin[0] = tbl[i].vin; bitv[0] = tbl[i].b; lastv[0] = tbl[i].l; ordy[0] = tbl[i].rdy;
      @(negedge clk);
      chk($sformatf("table_step%0d", i),
          {ov[0], irdy[0], (ov[0] ? {olast[0], sym_v[0][1:0]} : 3'b000)},
          {tbl[i].e_ov, tbl[i].e_irdy, tbl[i].e_last, tbl[i].e_sym});
      @(posedge clk); #1;
    end
    vin[0] = 1'b0;

    // Back-pressure on frame 1,0,1,1
    set_frames(16'b1101, 16'b1000, 4);
    exp_q.delete();
    push_exp(0, 2'b11); push_exp(0, 2'b01); push_exp(0, 2'b00);
    push_exp(0, 2'b10); push_exp(0, 2'b10); push_exp(1, 2'b11);
    stream(0, 1);
    cmp_q("backpressure");

    // Truncating instance: frame 1,0,1,1 then frame 1
    set_frames(16'b11101, 16'b11000, 5);
    exp_q.delete();
    push_exp(0, 2'b11); push_exp(0, 2'b01); push_exp(0, 2'b00);
    push_exp(1, 2'b10); push_exp(1, 2'b11);
    stream(1, 0);
    cmp_q("noterm");

    // Reset one cycle after in_last is accepted
    vin[0] = 1'b1; bitv[0] = 1'b1; lastv[0] = 1'b1; ordy[0] = 1'b1;
    @(negedge clk);
    chk("midtail_accept_ready", irdy[0], 1'b1);
    @(posedge clk); #1;
    vin[0] = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("midtail_pre_reset_valid", ov[0], 1'b1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midtail_out_valid", ov[0], 1'b0);
    chk("midtail_busy", busy_v[0], 1'b0);
    chk("midtail_in_ready", irdy[0], 1'b1);
    @(posedge clk); #1;
    set_frames(16'b1, 16'b1, 1);
    exp_q.delete();
    push_exp(0, 2'b11); push_exp(0, 2'b01); push_exp(1, 2'b11);
    stream(0, 0);
    cmp_q("after_reset");

    // K=5, N=3 sweep against the convolution model
    s_bit.delete();
    s_last.delete();
    lens.delete();
    exp_q.delete();
    for (int f = 0; f < 25; f++) begin
      int len;
      int base;
      len = int'($urandom_range(1, 10));
      base = s_bit.size();
      lens.push_back(len);
      for (int j = 0; j < len; j++) begin
        s_bit.push_back(1'($urandom_range(0, 1)));
        s_last.push_back(j == len - 1);
      end
      model_frame(base, len, KC, NC, 36'(G_C), 1'b1);
    end
    stream(2, 2);
    cmp_q("sweep");
    begin
      int f;
      int cnt;
      f = 0;
      cnt = 0;
      foreach (got_q[i]) begin
        cnt++;
        if (got_q[i][3]) begin
          if (f < lens.size()) chk($sformatf("sweep_frame%0d_len", f), cnt, lens[f] + KC - 1);
          f++;
          cnt = 0;
        end
      end
      chk("sweep_frames", f, lens.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
